// File: rtl/event_window_ctrl.sv
// event_window_ctrl
//   Sequences a gated event-counting measurement. A start request arms a
//   window timer and an event counter; events are counted only during the
//   len-cycle COUNT phase. At window end the result is latched and offered
//   on a valid/ready handshake. Optional repeat mode re-arms after each
//   accepted result.
//
//   Optional feature macro: EVENT_WINDOW_CTRL_SATURATE_EN
//     defined   -> event counter saturates at all-ones
//     undefined -> event counter wraps modulo 2^CNT_BITS
//   In both builds o_overflow flags the first event that arrives while the
//   counter is already all-ones (sticky until the next ARM).
//
// Ports
//   i_clk        system clock, rising edge
//   i_rst        asynchronous active-high reset
//   i_start      request a window (or a repeating series)
//   i_abort      terminate any activity, return to IDLE
//   i_repeat     sampled with i_start; re-arm after each handshake
//   i_window_len window length in cycles, sampled with i_start (0 ignored)
//   i_event      event strobe, one count per high cycle
//   o_busy       high whenever not IDLE
//   o_valid      result available
//   i_ready      consumer accepts the result
//   o_count      events counted in the completed window
//   o_overflow   an event was seen while the counter was all-ones
module event_window_ctrl #(
  parameter int CNT_BITS = 16,
  parameter int WIN_BITS = 24
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic                i_abort,
  input  logic                i_repeat,
  input  logic [WIN_BITS-1:0] i_window_len,
  input  logic                i_event,
  output logic                o_busy,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [CNT_BITS-1:0] o_count,
  output logic                o_overflow
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARM   = 2'd1,
    S_COUNT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state;
  logic [WIN_BITS-1:0] len_q;
  logic [WIN_BITS-1:0] timer;
  logic [CNT_BITS-1:0] cnt;
  logic                ovf;
  logic                rpt;

  // Next counter / overflow values for the current COUNT cycle. Computed
  // combinationally so the final COUNT cycle's event lands in the latched
  // result on the same edge that enters DONE.
  logic                cnt_full;
  logic [CNT_BITS-1:0] cnt_inc;
  logic [CNT_BITS-1:0] cnt_next;
  logic                ovf_next;
  logic                last_cycle;

  always_comb begin
    cnt_full = &cnt;
`ifdef EVENT_WINDOW_CTRL_SATURATE_EN
    cnt_inc  = cnt_full ? cnt : cnt + 1'b1;
`else
    cnt_inc  = cnt + 1'b1;
`endif
    cnt_next   = i_event ? cnt_inc : cnt;
    ovf_next   = ovf | (i_event & cnt_full);
    // len_q is never 0 here: a zero-length start is rejected in IDLE.
    last_cycle = (timer == (len_q - WIN_BITS'(1)));
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= S_IDLE;
      len_q      <= '0;
      timer      <= '0;
      cnt        <= '0;
      ovf        <= 1'b0;
      rpt        <= 1'b0;
      o_busy     <= 1'b0;
      o_valid    <= 1'b0;
      o_count    <= '0;
      o_overflow <= 1'b0;
    end else if (i_abort) begin
      // Abort wins over start and ready in the same cycle.
      state      <= S_IDLE;
      rpt        <= 1'b0;
      o_busy     <= 1'b0;
      o_valid    <= 1'b0;
      o_count    <= '0;
      o_overflow <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_start && (i_window_len != '0)) begin
            len_q  <= i_window_len;
            rpt    <= i_repeat;
            state  <= S_ARM;
            o_busy <= 1'b1;
          end
        end
        S_ARM: begin
          // Dead cycle: clear the measurement, events ignored.
          timer <= '0;
          cnt   <= '0;
          ovf   <= 1'b0;
          state <= S_COUNT;
        end
        S_COUNT: begin
          timer <= timer + 1'b1;
          cnt   <= cnt_next;
          ovf   <= ovf_next;
          if (last_cycle) begin
            state      <= S_DONE;
            o_valid    <= 1'b1;
            o_count    <= cnt_next;
            o_overflow <= ovf_next;
          end
        end
        S_DONE: begin
          // o_count/o_overflow simply hold; only the handshake moves us on.
          if (i_ready) begin
            o_valid <= 1'b0;
            if (rpt) begin
              state <= S_ARM;
            end else begin
              state  <= S_IDLE;
              o_busy <= 1'b0;
            end
          end
        end
        default: begin
          state  <= S_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_event_window_ctrl.sv
// Directed bench for event_window_ctrl. Stimulus pushes the hand-computed
// result of each window into a queue; a monitor pops and compares on every
// accepted handshake. Cycle-level behaviour (valid timing, busy, abort,
// reset) is checked inline against constants.
module tb_event_window_ctrl;
  localparam int CB = 4;
  localparam int WB = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0, abort = 1'b0, rpt = 1'b0, ev = 1'b0, ready = 1'b0;
  logic [WB-1:0] len = '0;
  logic          busy, valid, ovf;
  logic [CB-1:0] count;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [CB-1:0] cnt;
    logic          ovf;
  } res_t;
  res_t exp_q[$];

  event_window_ctrl #(.CNT_BITS(CB), .WIN_BITS(WB)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
    .i_repeat(rpt), .i_window_len(len), .i_event(ev),
    .o_busy(busy), .o_valid(valid), .i_ready(ready),
    .o_count(count), .o_overflow(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (valid) break;
      tick();
    end
    check(name, valid, 1);
  endtask

  // Monitor: a handshake completes at the next rising edge when valid and
  // ready are both high and abort is low.
  always @(negedge clk) begin
    if (!rst && valid && ready && !abort) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected: got count=%0d ovf=%0b expected no result", count, ovf);
      end else begin
        res_t e;
        e = exp_q.pop_front();
        if (count !== e.cnt || ovf !== e.ovf) begin
          fails++;
          $display("FAIL sb_result: got count=%0d ovf=%0b expected count=%0d ovf=%0b",
                   count, ovf, e.cnt, e.ovf);
        end
      end
    end
  end

  initial begin
    res_t r;
    // Reset state
    #2;
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_count", count, 0);
    check("rst_ovf", ovf, 0);
    tick();
    rst = 1'b0;
    tick();

    // Zero-length start ignored
    start = 1; len = 0;
    tick();
    start = 0;
    tick();
    check("len0_busy", busy, 0);

    // len=10, event in ARM plus 4 COUNT cycles, ready low 5 cycles
    r.cnt = 4; r.ovf = 0; exp_q.push_back(r);
    start = 1; len = 10; ev = 0;
    tick();                          // now in ARM
    start = 0; len = 0; ev = 1;      // ARM-cycle event must not count
    check("arm_busy", busy, 1);
    tick();
    for (int k = 0; k < 10; k++) begin
      ev = (k >= 3 && k < 7);
      start = (k == 5); len = (k == 5) ? 8'd3 : 8'd0;   // ignored mid-window
      check("count_novalid", valid, 0);
      tick();
    end
    ev = 0; start = 0;
    check("done_valid", valid, 1);
    for (int k = 0; k < 5; k++) begin
      start = (k == 2); len = 8'd3;  // ignored in DONE
      check("hold_valid", valid, 1);
      check("hold_count", count, 4);
      tick();
    end
    start = 0;
    ready = 1;
    tick();
    ready = 0;
    check("hs_valid", valid, 0);
    check("hs_busy", busy, 0);
    tick();
    check("idle_busy", busy, 0);

    // Repeat: len=5, ready high, event always high
    for (int w = 0; w < 3; w++) begin
      r.cnt = 5; r.ovf = 0; exp_q.push_back(r);
    end
    start = 1; len = 5; rpt = 1; ready = 1; ev = 1;
    tick();
    start = 0; rpt = 0; len = 1;     // late changes have no effect
    for (int i = 0; i < 21; i++) begin
      check("rpt_valid", valid, (i % 7 == 6));
      check("rpt_busy", busy, 1);
      tick();
    end
    tick(); tick();                  // ARM + 2 COUNT cycles of window 4
    check("rpt4_busy", busy, 1);
    abort = 1;
    tick();
    abort = 0;
    check("abort_busy", busy, 0);
    check("abort_valid", valid, 0);
    ready = 0; ev = 0;
    tick();

    // Overflow: len=20 with a 4-bit counter
`ifdef EVENT_WINDOW_CTRL_SATURATE_EN
    r.cnt = 15;
`else
    r.cnt = 4;
`endif
    r.ovf = 1; exp_q.push_back(r);
    start = 1; len = 20; ev = 1;
    tick();
    start = 0;
    wait_valid("ovf_valid", 40);
    ev = 0;
    ready = 1;
    tick();
    ready = 0;
    tick();

    // Abort and ready in the same DONE cycle with repeat set
    start = 1; len = 2; rpt = 1; ev = 1;
    tick();
    start = 0; rpt = 0; ev = 0;
    wait_valid("ab_valid", 10);
    abort = 1; ready = 1;
    tick();
    abort = 0; ready = 0;
    check("ab_busy", busy, 0);
    check("ab_valid0", valid, 0);
    check("ab_count", count, 0);
    tick(); tick();
    check("ab_stay_idle", busy, 0);

    // Async reset mid-COUNT
    start = 1; len = 10; ev = 1;
    tick();
    start = 0;
    tick(); tick(); tick();
    check("pre_rst_busy", busy, 1);
    #2 rst = 1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_valid", valid, 0);
    check("arst_count", count, 0);
    tick();
    rst = 0;
    tick();
    check("post_rst_busy", busy, 0);

    // Fresh count after reset
    r.cnt = 3; r.ovf = 0; exp_q.push_back(r);
    start = 1; len = 3; ev = 1; ready = 1;
    tick();
    start = 0;
    wait_valid("fresh_valid", 10);
    tick();
    ready = 0; ev = 0;
    tick();
    check("sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
